// File: rtl/back_rx_buf.sv
// -----------------------------------------------------------------------------
// back_rx_buf
//   Receive-side (B-domain) endpoint of a two-domain toggle handshake.
//   A request toggle from the A domain is synchronised into bclk. Each request
//   captures a_data into a DEPTH-entry buffer and flips the acknowledge toggle.
//   The buffer drains to the local consumer through a valid/load handshake.
//   While the buffer is full, a request is parked in a pending flag. Its
//   acknowledge is withheld until a slot frees, which stalls the sender.
//
// Parameters
//   DW          payload width (>= 1)
//   SYNC_STAGES synchroniser depth on a_req_tgl (>= 2)
//   DEPTH       buffer entries, power of 2 (>= 2)
//
// Ports
//   bclk       in   B-domain clock
//   brst_n     in   asynchronous active-low reset
//   a_req_tgl  in   request toggle from the A domain (asynchronous)
//   a_data     in   payload, held stable by the sender until it sees the ack
//   b_ack_tgl  out  acknowledge toggle back to the A domain (registered)
//   bvalid     out  buffer non-empty
//   bdata      out  oldest buffered word
//   bload      in   consumer takes bdata this cycle
//   bcount     out  occupancy, 0..DEPTH
//   berr       out  sticky underflow flag (only with BACK_RX_ERR_EN)
//
// Build option
//   BACK_RX_ERR_EN  adds berr, which is set by bload while bvalid=0.
// -----------------------------------------------------------------------------
module back_rx_buf #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input  logic                     bclk,
  input  logic                     brst_n,
  input  logic                     a_req_tgl,
  input  logic [DW-1:0]            a_data,
  output logic                     b_ack_tgl,
  output logic                     bvalid,
  output logic [DW-1:0]            bdata,
  input  logic                     bload,
  output logic [$clog2(DEPTH):0]   bcount
`ifdef BACK_RX_ERR_EN
  ,
  output logic                     berr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_AVAIL,
    OCC_FULL
  } occ_e;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_req_d;
  logic                   r_pend;
  logic                   r_ack;
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [DW-1:0]          r_mem [DEPTH];

  logic                   w_s_req;
  logic                   w_b_en;
  logic                   w_valid;
  logic                   w_pop;
  logic                   w_capture;
  occ_e                   w_occ;

  // Synchroniser plus edge detector: one b_en pulse per request toggle.
  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      r_sync  <= '0;
      r_req_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], a_req_tgl};
      r_req_d <= w_s_req;
    end
  end

  assign w_s_req = r_sync[SYNC_STAGES-1];
  assign w_b_en  = w_s_req ^ r_req_d;

  // Occupancy classification; FULL is the only state that stalls a capture.
  // NOTE: the default assignment first keeps this combinational block from
  // inferring a latch when no branch matches.
  always_comb begin
    w_occ = OCC_AVAIL;
    if (r_count == '0)
      w_occ = OCC_EMPTY;
    else if (r_count == FULL_CNT)
      w_occ = OCC_FULL;
  end

  assign w_valid = (w_occ != OCC_EMPTY);
  assign w_pop   = bload & w_valid;
  // A pop in the same cycle frees the slot the new word lands in.
  assign w_capture = (w_b_en | r_pend) & ((w_occ != OCC_FULL) | w_pop);

  // Handshake state, pointers and occupancy.
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      r_pend   <= 1'b0;
      r_ack    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_pend <= (w_b_en | r_pend) & ~w_capture;
      if (w_capture) begin
        r_ack    <= ~r_ack;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_capture) - CW'(w_pop);
    end
  end

  // Storage.
  // NOTE: the buffer is reset so bdata reads 0 out of reset; this costs a
  // reset net per storage bit but keeps the output deterministic.
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_capture) begin
      r_mem[r_wr_ptr] <= a_data;
    end
  end

  assign b_ack_tgl = r_ack;
  assign bvalid    = w_valid;
  assign bdata     = r_mem[r_rd_ptr];
  assign bcount    = r_count;

`ifdef BACK_RX_ERR_EN
  logic r_err;

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n)
      r_err <= 1'b0;
    else if (bload & ~w_valid)
      r_err <= 1'b1;
  end

  assign berr = r_err;
`endif

endmodule

// File: doc/back_rx_buf.md
# back_rx_buf

Parametrised receive-side (B-domain) endpoint for the two-domain toggle handshake. It accepts words from the A domain through a synchronised request toggle and stores up to DEPTH of them in a local buffer. It presents them to the B-domain consumer with a valid/load handshake and returns a toggle acknowledge to the sender. When the buffer is full, the acknowledge is withheld, which back-pressures the A domain.

## Interface
- DW, 8: data width, at least 1.
- SYNC_STAGES, 2: synchroniser flops on a_req_tgl, at least 2.
- DEPTH, 2: buffer entries, a power of 2, at least 2.
- bclk  in  1  B-domain clock.
- brst_n  in  1  reset; asynchronous, active-low; clock bclk.
- a_req_tgl  in  1  request toggle from A domain (asynchronous to bclk).
- a_data  in  DW  payload; the A side holds it stable from the a_req_tgl edge until it sees b_ack_tgl change.
- b_ack_tgl  out  1  acknowledge toggle to A domain; registered.
- bvalid  out  1  buffer non-empty.
- bdata  out  DW  oldest buffered word; meaningful only while bvalid=1.
- bload  in  1  consumer takes bdata this cycle.
- bcount  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- berr  out  1  present only with BACK_RX_ERR_EN (see Configuration).

## Operation
- Synchroniser
  - a_req_tgl passes through a SYNC_STAGES-flop chain to give s_req.
  - A further flop gives s_req_d.
  - b_en = s_req ^ s_req_d, a one-cycle pulse per request.
- Pending flag `pend`
  - Set by b_en.
  - Cleared by a capture.
  - b_en while pend=1 cannot occur, because the sender waits for the acknowledge.
- Capture condition: (b_en | pend) & (count<DEPTH | (bload & bvalid)).
- On capture:
  - a_data is written at wr_ptr, and wr_ptr increments mod DEPTH.
  - b_ack_tgl inverts.
  - pend clears, or is never set if the capture happens in the b_en cycle.
- On pop (bload & bvalid): rd_ptr increments mod DEPTH.
- Count update:
  - count += capture − pop.
  - Full plus bload plus request in the same cycle gives a simultaneous pop and push; count stays DEPTH.
- bload while bvalid=0 is ignored: no pointer or count change.
- Outputs
  - bvalid = (count != 0).
  - bdata = mem[rd_ptr], read combinationally from registered storage.
- Per-entry state generalises the two-state READY/WAIT scheme.
  - EMPTY (count=0): bvalid=0.
  - AVAIL (0<count<DEPTH): the block accepts and presents.
  - FULL (count=DEPTH): captures stall into pend.
- Reset (brst_n=0, immediate) clears the following:
  - synchroniser flops, s_req_d, pend, pointers and count;
  - b_ack_tgl=0, bvalid=0, bcount=0, berr=0;
  - mem contents to 0, so bdata=0.
- Reset mid-transfer discards buffered and pending words. The A side must be reset in the same event so its toggles re-align at 0.

## Timing
- Request latency
  - An a_req_tgl change before bclk edge 1 reaches s_req at edge SYNC_STAGES.
  - b_en is high in the following cycle.
  - Capture and the b_ack_tgl change occur at edge SYNC_STAGES+1.
  - bvalid is high after that edge (3 edges at SYNC_STAGES=2).
- Pop is effective at the edge where bload & bvalid is high; the next word appears on bdata after that edge.
- Full stall: the capture, and with it the b_ack_tgl change, occurs at the first edge where a pop happens or count<DEPTH.
- Throughput: one word per A-side round trip. The buffer absorbs consumer stalls up to DEPTH words.

## Configuration
- BACK_RX_ERR_EN defined:
  - Adds output berr, a sticky flag set at the edge where bload=1 and bvalid=0.
  - berr is cleared only by brst_n.
- Not defined: the berr port and its logic are absent, and underflow bload is silently ignored.

## Test plan
- Reset: hold brst_n=0 with a_req_tgl=1 -> b_ack_tgl=0, bvalid=0, bcount=0, bdata=0.
- Single transfer (SYNC_STAGES=2): a_data=8'hA5 with a_req_tgl 0->1 before edge 1 -> b_ack_tgl=1 and bvalid=1 after edge 3, bdata=8'hA5; bload for one cycle -> bvalid=0.
- Fill to full (DEPTH=2): send 8'h11 and 8'h22 without bload, then a third request 8'h33 -> bcount=2 and b_ack_tgl does not change; pulse bload -> bdata shows 8'h22 and 8'h33 is captured at the same edge, bcount stays 2, b_ack_tgl toggles.
- Simultaneous: bcount=1, bload=1 in the b_en cycle -> count unchanged at 1, bdata = the new word next cycle.
- Underflow (BACK_RX_ERR_EN): bload=1 with bvalid=0 -> no pointer change, berr=1 and it stays 1 until reset.
- Reset mid-operation: bcount=2 with pend=1, then assert brst_n -> all outputs return to reset values immediately, before the next bclk edge.
